resampler_sample_feeder: RTL and testbench
==========================================

# resampler_sample_feeder

Paced sample source that sits directly upstream of the interpolating polyphase filter. It accepts input samples over a ready/valid stream and buffers them in a FIFO. It then issues them to the filter's valid-only input no closer than INTERVAL cycles apart, because the filter ignores any valid_i it receives while still working through its phases. Default INTERVAL = 2*PHASES-1 = 15 matches the filter's busy window for PHASES = 8.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width in bits.
- DEPTH, 8, FIFO depth in samples; must be a power of 2 and ≥ 2.
- INTERVAL, 15, minimum cycles between consecutive m_valid_o pulses; must be ≥ 1.

Ports (LW = $clog2(DEPTH)+1):
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  1  emission enable; while low, no samples are issued and the FIFO keeps accepting.
- flush_i  in  1  synchronous flush of FIFO and pacing state.
- s_valid_i  in  1  upstream sample valid.
- s_ready_o  out  1  upstream ready; combinational: rst_n & ~flush_i & (level < DEPTH).
- s_data_i  in  DATA_WIDTH  upstream sample, signed.
- m_valid_o  out  1  registered one-cycle pulse; drives the filter's valid_i.
- m_data_o  out  DATA_WIDTH  registered sample; holds its last value between pulses.
- level_o  out  LW  registered FIFO occupancy, 0..DEPTH.
- underrun_o  out  1  registered one-cycle pulse when the source starves after streaming has started.

## Operation
- Push: s_valid_i & s_ready_o writes s_data_i at the write pointer. The pointer wraps modulo DEPTH.
- When full, s_ready_o is low, even if a pop occurs in the same cycle (no bypass).
- gap_cnt: loads INTERVAL-1 on each emission, otherwise decrements to 0 and saturates. It keeps counting while en_i is low, so spacing is preserved across enable toggles.
- Emit condition: en_i & ~flush_i & (gap_cnt == 0) & (level > 0), evaluated on the registered level.
- On emit, the next cycle has m_valid_o = 1 and m_data_o = head sample, and the read pointer advances.
- Level update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- A sample pushed into an empty FIFO is not emitted in its push cycle.
- armed flag: set on each emission; cleared by flush_i or by an underrun.
- Underrun condition: en_i & ~flush_i & armed & (gap_cnt == 0) & (level == 0). It gives one underrun_o pulse the next cycle and clears armed, so only one pulse is produced per starvation episode.
- flush_i high: write pointer, read pointer, level, gap_cnt and armed go to 0 next cycle; m_valid_o and underrun_o are 0 next cycle. The push is blocked because s_ready_o is low. m_data_o keeps its value.
- No arithmetic is performed on sample data; samples pass through bit-exact.

## Timing
- Reset (async assert) values: m_valid_o 0, m_data_o 0, level_o 0, underrun_o 0, pointers 0, gap_cnt 0, armed 0. s_ready_o is 0 while rst_n is low.
- Latency: push in cycle N into an idle, empty FIFO with en_i = 1 gives m_valid_o in cycle N+2.
- Spacing: with the FIFO non-empty, m_valid_o rising edges are exactly INTERVAL cycles apart. INTERVAL = 1 gives a back-to-back pulse every cycle.
- en_i rising: emission happens as soon as gap_cnt == 0; there is no extra delay.
- A reset asserted in the middle of a stream drops all buffered samples; any m_valid_o pulse in flight goes to 0 immediately.

## Test plan
- Push 0x0001..0x0004 back-to-back, en_i = 1, INTERVAL = 15: m_valid_o pulses at cycles P, P+15, P+30, P+45 with data 1,2,3,4 in order. Level peaks at 3 or 4. No underrun.
- Fill 8 samples with en_i = 0: level_o = 8 and s_ready_o = 0. A 9th push attempt is not accepted. Raise en_i: 8 pulses 15 cycles apart, then one underrun_o pulse 15 cycles after the last pulse.
- INTERVAL = 1 with continuous push: a pulse every cycle and level stable. A simultaneous push and pop leaves level unchanged.
- Emit one sample, then let the FIFO run empty: exactly one underrun_o pulse. A fresh push restarts pulses, with the first sample following the 2-cycle latency rule.
- Load 5 samples, assert flush_i for 1 cycle in the middle of the gap: level_o = 0 and there are no further pulses or underrun. A new push then emits with 2-cycle latency.
- Assert rst_n low while level = 3 and m_valid_o = 1: all outputs return to their reset values immediately, and no stale sample is emitted after release.

Source files
------------

// File: rtl/resampler_sample_feeder.sv
// resampler_sample_feeder
//   Paced sample source for the polyphase interpolator. Samples arrive on a
//   ready/valid stream and are buffered in a FIFO. They are issued on a
//   valid-only port, with at least INTERVAL cycles between pulses, so that
//   no sample lands while the filter is still cycling through its phases.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en_i                  emission enable (FIFO still accepts while low)
//   flush_i               sync flush of FIFO, pacing and armed state
//   s_valid_i/s_ready_o   upstream handshake, s_data_i sample
//   m_valid_o/m_data_o    registered pulse + held sample to the filter
//   level_o               registered FIFO occupancy 0..DEPTH
//   underrun_o            one-cycle pulse when the source starves mid-stream
module resampler_sample_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int INTERVAL   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [DATA_WIDTH-1:0]  s_data_i,
  output logic                   m_valid_o,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   underrun_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(INTERVAL - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic [GW-1:0]         gap_cnt;
  logic                  armed;
  logic                  push, emit, starve, gap_done;

  // Full means not ready even if a pop happens this cycle: no bypass path.
  assign s_ready_o = rst_n & ~flush_i & (level < FULL);
  assign push      = s_valid_i & s_ready_o;
  assign gap_done  = (gap_cnt == '0);
  assign emit      = en_i & ~flush_i & gap_done & (level != '0);
  // armed gates this so a starvation episode yields exactly one pulse.
  assign starve    = en_i & ~flush_i & armed & gap_done & (level == '0);
  assign level_o   = level;

  // Sample storage carries no reset; occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      gap_cnt    <= '0;
      armed      <= 1'b0;
      m_valid_o  <= 1'b0;
      m_data_o   <= '0;
      underrun_o <= 1'b0;
    end else if (flush_i) begin
      // m_data_o deliberately keeps its last value across a flush.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      gap_cnt    <= '0;
      armed      <= 1'b0;
      m_valid_o  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      m_valid_o  <= emit;
      underrun_o <= starve;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (emit) begin
        m_data_o <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({push, emit})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Pacing keeps running while en_i is low so spacing survives toggles.
      if (emit)           gap_cnt <= GAP_LOAD;
      else if (!gap_done) gap_cnt <= gap_cnt - 1'b1;
      if (emit)        armed <= 1'b1;
      else if (starve) armed <= 1'b0;
    end
  end
endmodule

// File: tb/tb_resampler_sample_feeder.sv
module tb_resampler_sample_feeder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0, flush_i = 1'b0, s_valid_i = 1'b0;
  logic [15:0] s_data_i = '0;
  logic        s_ready_o, m_valid_o, underrun_o;
  logic [15:0] m_data_o;
  logic [3:0]  level_o;

  logic        en1 = 1'b0, fl1 = 1'b0, v1 = 1'b0;
  logic [15:0] d1 = '0;
  logic        rdy1, mv1, ur1;
  logic [15:0] md1;
  logic [3:0]  lv1;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  resampler_sample_feeder #(.DATA_WIDTH(16), .DEPTH(8), .INTERVAL(15)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .level_o(level_o),
    .underrun_o(underrun_o));

  resampler_sample_feeder #(.DATA_WIDTH(16), .DEPTH(8), .INTERVAL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en1), .flush_i(fl1),
    .s_valid_i(v1), .s_ready_o(rdy1), .s_data_i(d1),
    .m_valid_o(mv1), .m_data_o(md1), .level_o(lv1),
    .underrun_o(ur1));

  // Reference model: a queue of buffered samples plus the edge index of the
  // last emission; an emission is allowed once INTERVAL edges have elapsed.
  logic [15:0] q[$];
  int          t = 0;
  int          last = -1000000;
  bit          armed = 0;
  logic        e_mv = 0, e_ur = 0;
  logic [15:0] e_md = '0;

  task automatic model_reset();
    q.delete(); last = -1000000; armed = 0; e_mv = 0; e_ur = 0; e_md = '0;
  endtask

  // Drive one cycle of inputs, advance the model, observe after the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic en, input logic fl);
    bit rdy, gap_ok, emit, ur;
    s_valid_i = v; s_data_i = d; en_i = en; flush_i = fl;
    rdy = (q.size() < 8) && !fl;
    if (fl) begin
      q.delete(); last = -1000000; armed = 0; e_mv = 0; e_ur = 0;
    end else begin
      gap_ok = (t - last) >= 15;
      emit = en && gap_ok && (q.size() > 0);
      ur   = en && armed && gap_ok && (q.size() == 0);
      e_mv = emit; e_ur = ur;
      if (emit) begin e_md = q.pop_front(); last = t; armed = 1; end
      if (ur) armed = 0;
      if (v && rdy) q.push_back(d);
    end
    @(posedge clk); #1; t++;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (m_valid_o !== 0 || m_data_o !== 0 || level_o !== 0 || underrun_o !== 0 || s_ready_o !== 0) begin
      bad++; $display("FAIL reset_state mv=%b md=%h lv=%0d ur=%b rdy=%b want all 0", m_valid_o, m_data_o, level_o, underrun_o, s_ready_o);
    end
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1; #1;
    total++;
    if (s_ready_o !== 1 || rdy1 !== 1) begin
      bad++; $display("FAIL ready_after_reset got=%b/%b want 1/1", s_ready_o, rdy1);
    end
  endtask

  task automatic test_stream();
    int pt[$]; logic [15:0] pd[$]; int peak = 0; int early_ur = 0;
    for (int i = 0; i < 78; i++) begin
      if (i < 4) step(1'b1, 16'(i + 1), 1'b1, 1'b0); else step(1'b0, 16'h0, 1'b1, 1'b0);
      total++;
      if (m_valid_o !== e_mv || m_data_o !== e_md || level_o !== 4'(q.size()) || underrun_o !== e_ur) begin
        bad++; $display("FAIL stream_cycle t=%0d got mv=%b md=%h lv=%0d ur=%b want %b %h %0d %b", t, m_valid_o, m_data_o, level_o, underrun_o, e_mv, e_md, q.size(), e_ur);
      end
      if (i == 0) begin
        total++;
        if (m_valid_o !== 0) begin bad++; $display("FAIL stream_no_same_cycle got=%b want 0", m_valid_o); end
      end
      if (i == 1) begin
        total++;
        if (m_valid_o !== 1) begin bad++; $display("FAIL stream_latency got=%b want 1", m_valid_o); end
      end
      if (int'(level_o) > peak) peak = int'(level_o);
      if (m_valid_o === 1'b1) begin pt.push_back(t); pd.push_back(m_data_o); end
      if (underrun_o === 1'b1 && pt.size() < 4) early_ur++;
    end
    total++;
    if (pt.size() != 4) begin bad++; $display("FAIL stream_pulse_count got=%0d want 4", pt.size()); end
    else for (int k = 0; k < 4; k++) begin
      total++;
      if (pd[k] !== 16'(k + 1) || (k > 0 && pt[k] - pt[k-1] != 15)) begin
        bad++; $display("FAIL stream_pulse%0d data=%h gap=%0d want data=%h gap=15", k, pd[k], (k > 0) ? pt[k] - pt[k-1] : 15, k + 1);
      end
    end
    total++;
    if (peak < 3 || peak > 4 || early_ur != 0) begin
      bad++; $display("FAIL stream_peak_ur peak=%0d early_ur=%0d want 3..4 and 0", peak, early_ur);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_fill();
    int np = 0, nu = 0, lastp = 0, urt = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    total++;
    if (level_o !== 8 || s_ready_o !== 0) begin
      bad++; $display("FAIL fill_full lv=%0d rdy=%b want 8 0", level_o, s_ready_o);
    end
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    total++;
    if (level_o !== 8 || q.size() != 8) begin
      bad++; $display("FAIL fill_ninth lv=%0d want 8", level_o);
    end
    for (int i = 0; i < 8 * 15 + 20; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      total++;
      if (m_valid_o !== e_mv || m_data_o !== e_md || level_o !== 4'(q.size()) || underrun_o !== e_ur) begin
        bad++; $display("FAIL fill_cycle t=%0d got mv=%b md=%h lv=%0d ur=%b want %b %h %0d %b", t, m_valid_o, m_data_o, level_o, underrun_o, e_mv, e_md, q.size(), e_ur);
      end
      if (m_valid_o === 1'b1) begin np++; lastp = t; end
      if (underrun_o === 1'b1) begin nu++; urt = t; end
    end
    total++;
    if (np != 8 || nu != 1 || urt - lastp != 15) begin
      bad++; $display("FAIL fill_drain pulses=%0d ur=%0d ur_delay=%0d want 8 1 15", np, nu, urt - lastp);
    end
  endtask

  task automatic test_underrun_restart();
    int nu = 0; logic [15:0] d;
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      total++;
      if (m_valid_o !== e_mv || m_data_o !== e_md || level_o !== 4'(q.size()) || underrun_o !== e_ur) begin
        bad++; $display("FAIL starve_cycle t=%0d got mv=%b md=%h lv=%0d ur=%b want %b %h %0d %b", t, m_valid_o, m_data_o, level_o, underrun_o, e_mv, e_md, q.size(), e_ur);
      end
      if (underrun_o === 1'b1) nu++;
    end
    total++;
    if (nu != 1) begin bad++; $display("FAIL starve_single_ur got=%0d want 1", nu); end
    d = 16'($urandom);
    step(1'b1, d, 1'b1, 1'b0);
    total++;
    if (m_valid_o !== 0) begin bad++; $display("FAIL restart_same_cycle got=%b want 0", m_valid_o); end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    total++;
    if (m_valid_o !== 1 || m_data_o !== d) begin
      bad++; $display("FAIL restart_latency mv=%b md=%h want 1 %h", m_valid_o, m_data_o, d);
    end
  endtask

  task automatic test_flush();
    int np = 0, nu = 0; logic [15:0] d;
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    total++;
    if (level_o !== 0 || m_valid_o !== 0 || underrun_o !== 0) begin
      bad++; $display("FAIL flush_clear lv=%0d mv=%b ur=%b want 0 0 0", level_o, m_valid_o, underrun_o);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      if (m_valid_o === 1'b1) np++;
      if (underrun_o === 1'b1) nu++;
    end
    total++;
    if (np != 0 || nu != 0) begin bad++; $display("FAIL flush_quiet pulses=%0d ur=%0d want 0 0", np, nu); end
    d = 16'($urandom);
    step(1'b1, d, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    total++;
    if (m_valid_o !== 1 || m_data_o !== d) begin
      bad++; $display("FAIL flush_restart mv=%b md=%h want 1 %h", m_valid_o, m_data_o, d);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom), 16'($urandom), ($urandom % 4) != 0, ($urandom % 50) == 0);
      total++;
      if (m_valid_o !== e_mv || m_data_o !== e_md || level_o !== 4'(q.size()) || underrun_o !== e_ur
          || s_ready_o !== ((q.size() < 8) && !flush_i)) begin
        bad++; $display("FAIL random_cycle t=%0d got mv=%b md=%h lv=%0d ur=%b rdy=%b want %b %h %0d %b", t, m_valid_o, m_data_o, level_o, underrun_o, s_ready_o, e_mv, e_md, q.size(), e_ur);
      end
    end
    step(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  // INTERVAL = 1 instance: every pushed sample leaves on the following edge.
  task automatic test_interval1();
    logic [15:0] prev = '0, d;
    for (int i = 0; i < 30; i++) begin
      d = 16'($urandom);
      v1 = 1'b1; d1 = d; en1 = 1'b1;
      @(posedge clk); #1;
      total++;
      if (i == 0) begin
        if (mv1 !== 0 || lv1 !== 1) begin bad++; $display("FAIL int1_first mv=%b lv=%0d want 0 1", mv1, lv1); end
      end else if (mv1 !== 1 || md1 !== prev || lv1 !== 1 || ur1 !== 0) begin
        bad++; $display("FAIL int1_cycle%0d mv=%b md=%h lv=%0d ur=%b want 1 %h 1 0", i, mv1, md1, lv1, ur1, prev);
      end
      prev = d;
    end
    v1 = 1'b0; en1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int np = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hA0 + i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    total++;
    if (m_valid_o !== 1 || level_o !== 3 || m_data_o !== 16'hA0) begin
      bad++; $display("FAIL rstmid_setup mv=%b lv=%0d md=%h want 1 3 00a0", m_valid_o, level_o, m_data_o);
    end
    #2 rst_n = 1'b0; #1;
    model_reset();
    total++;
    if (m_valid_o !== 0 || m_data_o !== 0 || level_o !== 0 || underrun_o !== 0 || s_ready_o !== 0) begin
      bad++; $display("FAIL rstmid_async mv=%b md=%h lv=%0d ur=%b rdy=%b want all 0", m_valid_o, m_data_o, level_o, underrun_o, s_ready_o);
    end
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      if (m_valid_o === 1'b1 || underrun_o === 1'b1 || level_o !== 0) np++;
    end
    total++;
    if (np != 0) begin bad++; $display("FAIL rstmid_stale bad_cycles=%0d want 0", np); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_underrun_restart();
    test_flush();
    test_random();
    test_interval1();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
